branch_rs: RTL and testbench
============================

Name: branch_rs

Overview:
- 4-entry reservation station for branch-class ops (B, BL, CBZ, CBNZ, RET). Sits between rename/dispatch and the branch execute stage.
- Holds dispatched branches and captures missing operands from the CDB.
- Each cycle, issues the oldest entry with both operands ready to the branch execute stage as a registered, one-op-per-cycle issue bundle.

Parameters:
XLEN, core_pkg::XLEN, datapath width
PHYS_W, core_pkg::LOG2_PREGS, physical register tag width
DEPTH, 4, number of entries (2..8)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  pipeline flush; discards all entries
disp_valid  in  1  dispatch request
disp_ready  out  1  RS can accept a dispatch this cycle
disp_op  in  8  op field ({opcode[5:0], sub[1:0]}; RET keeps func in [5:0])
disp_dst_tag  in  PHYS_W  destination physical tag
disp_src1_tag  in  PHYS_W  source 1 physical tag
disp_src1_rdy  in  1  source 1 value valid at dispatch
disp_src1_val  in  XLEN  source 1 value
disp_src2_tag  in  PHYS_W  source 2 physical tag
disp_src2_rdy  in  1  source 2 value valid at dispatch
disp_src2_val  in  XLEN  source 2 value
disp_pc  in  XLEN  branch PC
disp_imm  in  XLEN  branch offset, already <<2
disp_rob_tag  in  6  ROB index
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  PHYS_W  CDB tag
cdb_value  in  XLEN  CDB value
issue_valid  out  1  issue bundle valid
issue_op  out  8  issued op
issue_dst_tag  out  PHYS_W  issued destination tag
issue_src1_val  out  XLEN  issued source 1 value
issue_src2_val  out  XLEN  issued source 2 value
issue_pc  out  XLEN  issued PC
issue_imm  out  XLEN  issued offset
issue_rob_tag  out  6  issued ROB index
occupancy  out  $clog2(DEPTH+1)  live entry count

Behaviour:
- Reset: all entries invalid. issue_valid=0, all issue_* data=0, occupancy=0, disp_ready=1.
- Storage is a collapsing queue: entry 0 is the oldest, and new entries append at index occupancy.
  - Per entry: valid, op, dst, src tags, rdy bits, values, pc, imm, rob_tag.
- disp_ready = (occupancy < DEPTH), combinational from registered occupancy.
  - A dispatch while full is ignored.
  - Issue in the same cycle does not free a slot for that cycle's dispatch.
- Dispatch accepted (disp_valid && disp_ready && !flush): written at the clock edge.
  - For each source with rdy=0: if cdb_valid and cdb_tag matches this cycle, the entry is written with rdy=1 and val=cdb_value.
- Wakeup: every valid entry with srcN_rdy=0 and a matching cdb_tag (cdb_valid=1) sets rdy=1 and latches cdb_value at the edge.
  - The entry becomes issue-eligible the following cycle; there is no same-cycle CDB-to-issue bypass.
- Select: lowest index with valid && src1_rdy && src2_rdy.
  - At the edge: issue_* <= that entry, issue_valid <= 1, the entry is removed, and younger entries shift down one index.
  - Shifting entries still apply same-cycle CDB wakeup.
  - Latency is dispatch-to-issue_valid ≥ 1 cycle, exactly 1 if operands are ready at dispatch.
- No eligible entry: issue_valid <= 0; issue_* data hold their previous values.
- occupancy next = occupancy + dispatch_accepted − issued.
- Simultaneous dispatch and issue:
  - Net occupancy is unchanged.
  - The new entry lands at occupancy−1 after the collapse.
- flush: at the edge all entries are invalidated, occupancy <= 0, issue_valid <= 0. Dispatch and wakeup in that cycle are discarded. Flush overrides everything except reset.
- Reset asserted mid-operation: immediate clear to reset values, independent of clk.
- RS does not interpret op semantics. Unused sources (e.g. B, BL) are dispatched with rdy=1.

Test Plan:
- Reset then dispatch CBZ {pc=0x100, imm=0x20, src1_rdy=1, src1_val=0, rob=5} → next cycle issue_valid=1, issue_pc=0x100, issue_imm=0x20, issue_rob_tag=5; occupancy returns to 0.
- Dispatch CBNZ with src1_rdy=0, tag=12; two cycles later CDB {tag=12, value=7} → issue_valid=1 exactly one cycle after the CDB, issue_src1_val=7.
- Dispatch A (not ready, tag 3), then B (ready) → B issues first. Then CDB tag 3 → A issues; ordering and collapse are correct.
- Fill 4 entries, none ready → disp_ready=0, occupancy=4, and a 5th dispatch is ignored. Wake entry 0 → after issue occupancy=3, disp_ready=1.
- Dispatch in the same cycle as a CDB with a matching tag → entry captured as ready and issued the next cycle with the CDB value.
- Three entries present, assert flush together with disp_valid → next cycle occupancy=0, issue_valid=0, dropped dispatch never issues. Async reset mid-stream clears outputs without a clock edge.

Source files
------------

// File: rtl/branch_rs_if.sv
// Core-wide sizing constants plus the dispatch / CDB / issue bundle that
// connects the branch reservation station to its neighbours.
package core_pkg;
  localparam int XLEN       = 32;
  localparam int LOG2_PREGS = 6;
endpackage

interface branch_rs_if #(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int PHYS_W = core_pkg::LOG2_PREGS
);
  logic              disp_valid;
  logic              disp_ready;
  logic [7:0]        disp_op;
  logic [PHYS_W-1:0] disp_dst_tag;
  logic [PHYS_W-1:0] disp_src1_tag;
  logic              disp_src1_rdy;
  logic [XLEN-1:0]   disp_src1_val;
  logic [PHYS_W-1:0] disp_src2_tag;
  logic              disp_src2_rdy;
  logic [XLEN-1:0]   disp_src2_val;
  logic [XLEN-1:0]   disp_pc;
  logic [XLEN-1:0]   disp_imm;
  logic [5:0]        disp_rob_tag;
  logic              flush;
  logic              cdb_valid;
  logic [PHYS_W-1:0] cdb_tag;
  logic [XLEN-1:0]   cdb_value;
  logic              issue_valid;
  logic [7:0]        issue_op;
  logic [PHYS_W-1:0] issue_dst_tag;
  logic [XLEN-1:0]   issue_src1_val;
  logic [XLEN-1:0]   issue_src2_val;
  logic [XLEN-1:0]   issue_pc;
  logic [XLEN-1:0]   issue_imm;
  logic [5:0]        issue_rob_tag;

  modport master (
    output disp_valid, disp_op, disp_dst_tag, disp_src1_tag, disp_src1_rdy,
           disp_src1_val, disp_src2_tag, disp_src2_rdy, disp_src2_val,
           disp_pc, disp_imm, disp_rob_tag, flush, cdb_valid, cdb_tag, cdb_value,
    input  disp_ready, issue_valid, issue_op, issue_dst_tag, issue_src1_val,
           issue_src2_val, issue_pc, issue_imm, issue_rob_tag
  );

  modport slave (
    input  disp_valid, disp_op, disp_dst_tag, disp_src1_tag, disp_src1_rdy,
           disp_src1_val, disp_src2_tag, disp_src2_rdy, disp_src2_val,
           disp_pc, disp_imm, disp_rob_tag, flush, cdb_valid, cdb_tag, cdb_value,
    output disp_ready, issue_valid, issue_op, issue_dst_tag, issue_src1_val,
           issue_src2_val, issue_pc, issue_imm, issue_rob_tag
  );
endinterface

// File: rtl/branch_rs.sv
// Branch reservation station: collapsing in-order queue with CDB wakeup and
// a registered oldest-ready issue bundle.
module branch_rs #(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int PHYS_W = core_pkg::LOG2_PREGS,
  parameter int DEPTH  = 4,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  branch_rs_if.slave       rs,
  output logic [OCC_W-1:0] occupancy
);

  typedef struct packed {
    logic              valid;
    logic [7:0]        op;
    logic [PHYS_W-1:0] dst;
    logic [PHYS_W-1:0] src1_tag;
    logic              src1_rdy;
    logic [XLEN-1:0]   src1_val;
    logic [PHYS_W-1:0] src2_tag;
    logic              src2_rdy;
    logic [XLEN-1:0]   src2_val;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [5:0]        rob_tag;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];
  entry_t ent_w [DEPTH];
  entry_t ent_s [DEPTH];
  entry_t disp_ent;

  logic [OCC_W-1:0]  occ_q, occ_d, slot, sel;
  logic              issue_hit, disp_acc, full;

  logic              issue_valid_q, issue_valid_d;
  logic [7:0]        issue_op_q, issue_op_d;
  logic [PHYS_W-1:0] issue_dst_q, issue_dst_d;
  logic [XLEN-1:0]   issue_src1_q, issue_src1_d;
  logic [XLEN-1:0]   issue_src2_q, issue_src2_d;
  logic [XLEN-1:0]   issue_pc_q, issue_pc_d;
  logic [XLEN-1:0]   issue_imm_q, issue_imm_d;
  logic [5:0]        issue_rob_q, issue_rob_d;

  assign full     = (occ_q >= OCC_W'(DEPTH));
  assign disp_acc = rs.disp_valid && !full && !rs.flush;

  // Wakeup and oldest-ready select; select looks only at registered ready bits.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_w[i] = ent_q[i];
      if (rs.cdb_valid && ent_q[i].valid) begin
        if (!ent_q[i].src1_rdy && (ent_q[i].src1_tag == rs.cdb_tag)) begin
          ent_w[i].src1_rdy = 1'b1;
          ent_w[i].src1_val = rs.cdb_value;
        end
        if (!ent_q[i].src2_rdy && (ent_q[i].src2_tag == rs.cdb_tag)) begin
          ent_w[i].src2_rdy = 1'b1;
          ent_w[i].src2_val = rs.cdb_value;
        end
      end
    end
    issue_hit = 1'b0;
    sel       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy) begin
        issue_hit = 1'b1;
        sel       = OCC_W'(i);
      end
    end
  end

  always_comb begin
    disp_ent          = '0;
    disp_ent.valid    = 1'b1;
    disp_ent.op       = rs.disp_op;
    disp_ent.dst      = rs.disp_dst_tag;
    disp_ent.src1_tag = rs.disp_src1_tag;
    disp_ent.src1_rdy = rs.disp_src1_rdy;
    disp_ent.src1_val = rs.disp_src1_val;
    disp_ent.src2_tag = rs.disp_src2_tag;
    disp_ent.src2_rdy = rs.disp_src2_rdy;
    disp_ent.src2_val = rs.disp_src2_val;
    disp_ent.pc       = rs.disp_pc;
    disp_ent.imm      = rs.disp_imm;
    disp_ent.rob_tag  = rs.disp_rob_tag;
    if (rs.cdb_valid && !rs.disp_src1_rdy && (rs.disp_src1_tag == rs.cdb_tag)) begin
      disp_ent.src1_rdy = 1'b1;
      disp_ent.src1_val = rs.cdb_value;
    end
    if (rs.cdb_valid && !rs.disp_src2_rdy && (rs.disp_src2_tag == rs.cdb_tag)) begin
      disp_ent.src2_rdy = 1'b1;
      disp_ent.src2_val = rs.cdb_value;
    end
  end

  // Collapse above the issued slot, then append at the post-collapse tail.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      ent_s[i] = ent_w[i + 1];
    end
    ent_s[DEPTH-1] = '0;
    slot  = occ_q - OCC_W'(issue_hit);
    occ_d = occ_q + OCC_W'(disp_acc) - OCC_W'(issue_hit);
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (issue_hit && (OCC_W'(i) >= sel)) ? ent_s[i] : ent_w[i];
      if (disp_acc && (OCC_W'(i) == slot)) begin
        ent_d[i] = disp_ent;
      end
    end
    if (rs.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i] = '0;
      end
      occ_d = '0;
    end
  end

  always_comb begin
    issue_valid_d = issue_hit && !rs.flush;
    issue_op_d    = issue_op_q;
    issue_dst_d   = issue_dst_q;
    issue_src1_d  = issue_src1_q;
    issue_src2_d  = issue_src2_q;
    issue_pc_d    = issue_pc_q;
    issue_imm_d   = issue_imm_q;
    issue_rob_d   = issue_rob_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_valid_d && (OCC_W'(i) == sel)) begin
        issue_op_d   = ent_q[i].op;
        issue_dst_d  = ent_q[i].dst;
        issue_src1_d = ent_q[i].src1_val;
        issue_src2_d = ent_q[i].src2_val;
        issue_pc_d   = ent_q[i].pc;
        issue_imm_d  = ent_q[i].imm;
        issue_rob_d  = ent_q[i].rob_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      occ_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_op_q    <= '0;
      issue_dst_q   <= '0;
      issue_src1_q  <= '0;
      issue_src2_q  <= '0;
      issue_pc_q    <= '0;
      issue_imm_q   <= '0;
      issue_rob_q   <= '0;
    end else begin
      ent_q         <= ent_d;
      occ_q         <= occ_d;
      issue_valid_q <= issue_valid_d;
      issue_op_q    <= issue_op_d;
      issue_dst_q   <= issue_dst_d;
      issue_src1_q  <= issue_src1_d;
      issue_src2_q  <= issue_src2_d;
      issue_pc_q    <= issue_pc_d;
      issue_imm_q   <= issue_imm_d;
      issue_rob_q   <= issue_rob_d;
    end
  end

  assign rs.disp_ready     = !full;
  assign rs.issue_valid    = issue_valid_q;
  assign rs.issue_op       = issue_op_q;
  assign rs.issue_dst_tag  = issue_dst_q;
  assign rs.issue_src1_val = issue_src1_q;
  assign rs.issue_src2_val = issue_src2_q;
  assign rs.issue_pc       = issue_pc_q;
  assign rs.issue_imm      = issue_imm_q;
  assign rs.issue_rob_tag  = issue_rob_q;
  assign occupancy         = occ_q;

endmodule

// File: tb/tb_branch_rs.sv
// Bench for branch_rs: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_branch_rs;
  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0]  op;
    logic [5:0]  dst;
    logic [5:0]  t1;
    bit          r1;
    logic [31:0] v1;
    logic [5:0]  t2;
    bit          r2;
    logic [31:0] v2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [5:0]  rob;
  } m_ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] occupancy;

  branch_rs_if #(.XLEN(32), .PHYS_W(6)) bus ();

  branch_rs #(.XLEN(32), .PHYS_W(6), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .rs        (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list ordered by age, plus the expected issue bundle.
  m_ent_t      m_q[$];
  bit          e_valid;
  logic [7:0]  e_op;
  logic [5:0]  e_dst, e_rob;
  logic [31:0] e_v1, e_v2, e_pc, e_imm;

  always @(posedge clk or posedge reset) begin : model
    int     sel;
    bit     acc;
    m_ent_t n;
    if (reset) begin
      m_q.delete();
      e_valid = 0; e_op = 0; e_dst = 0; e_rob = 0;
      e_v1 = 0; e_v2 = 0; e_pc = 0; e_imm = 0;
    end else if (bus.flush) begin
      m_q.delete();
      e_valid = 0;
    end else begin
      sel = -1;
      for (int i = 0; i < m_q.size(); i++)
        if (sel < 0 && m_q[i].r1 && m_q[i].r2) sel = i;
      acc = bus.disp_valid && (m_q.size() < DEPTH);
      if (sel >= 0) begin
        e_valid = 1;
        e_op = m_q[sel].op; e_dst = m_q[sel].dst; e_rob = m_q[sel].rob;
        e_v1 = m_q[sel].v1; e_v2 = m_q[sel].v2;
        e_pc = m_q[sel].pc; e_imm = m_q[sel].imm;
        m_q.delete(sel);
      end else begin
        e_valid = 0;
      end
      if (bus.cdb_valid) begin
        for (int i = 0; i < m_q.size(); i++) begin
          n = m_q[i];
          if (!n.r1 && n.t1 == bus.cdb_tag) begin n.r1 = 1; n.v1 = bus.cdb_value; end
          if (!n.r2 && n.t2 == bus.cdb_tag) begin n.r2 = 1; n.v2 = bus.cdb_value; end
          m_q[i] = n;
        end
      end
      if (acc) begin
        n.op = bus.disp_op; n.dst = bus.disp_dst_tag; n.rob = bus.disp_rob_tag;
        n.t1 = bus.disp_src1_tag; n.r1 = bus.disp_src1_rdy; n.v1 = bus.disp_src1_val;
        n.t2 = bus.disp_src2_tag; n.r2 = bus.disp_src2_rdy; n.v2 = bus.disp_src2_val;
        n.pc = bus.disp_pc; n.imm = bus.disp_imm;
        if (bus.cdb_valid && !n.r1 && n.t1 == bus.cdb_tag) begin n.r1 = 1; n.v1 = bus.cdb_value; end
        if (bus.cdb_valid && !n.r2 && n.t2 == bus.cdb_tag) begin n.r2 = 1; n.v2 = bus.cdb_value; end
        m_q.push_back(n);
      end
    end
    #1;
    chk("issue_valid", bus.issue_valid, e_valid);
    chk("issue_op", bus.issue_op, e_op);
    chk("issue_dst_tag", bus.issue_dst_tag, e_dst);
    chk("issue_src1_val", bus.issue_src1_val, e_v1);
    chk("issue_src2_val", bus.issue_src2_val, e_v2);
    chk("issue_pc", bus.issue_pc, e_pc);
    chk("issue_imm", bus.issue_imm, e_imm);
    chk("issue_rob_tag", bus.issue_rob_tag, e_rob);
    chk("occupancy", occupancy, m_q.size());
    chk("disp_ready", bus.disp_ready, m_q.size() < DEPTH);
  end

  task automatic idle();
    bus.disp_valid = 0;
    bus.cdb_valid  = 0;
    bus.flush      = 0;
  endtask

  task automatic set_disp(input logic [7:0] op, input logic [5:0] rob,
                          input bit r1, input logic [5:0] t1, input logic [31:0] v1,
                          input bit r2, input logic [5:0] t2, input logic [31:0] v2,
                          input logic [31:0] pc, input logic [31:0] imm);
    bus.disp_valid = 1;
    bus.disp_op = op; bus.disp_dst_tag = rob; bus.disp_rob_tag = rob;
    bus.disp_src1_rdy = r1; bus.disp_src1_tag = t1; bus.disp_src1_val = v1;
    bus.disp_src2_rdy = r2; bus.disp_src2_tag = t2; bus.disp_src2_val = v2;
    bus.disp_pc = pc; bus.disp_imm = imm;
  endtask

  task automatic set_cdb(input logic [5:0] t, input logic [31:0] v);
    bus.cdb_valid = 1; bus.cdb_tag = t; bus.cdb_value = v;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle();
    set_disp(8'h0, 6'd0, 1, 6'd0, 32'h0, 1, 6'd0, 32'h0, 32'h0, 32'h0);
    bus.disp_valid = 0;
    bus.cdb_tag = 0; bus.cdb_value = 0;
    step(3);
    chk("rst_issue_valid", bus.issue_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_disp_ready", bus.disp_ready, 1);
    chk("rst_issue_pc", bus.issue_pc, 0);
    reset = 0;
    step(1);

    // CBZ ready at dispatch: issues one cycle later
    set_disp(8'hB4, 6'd5, 1, 6'd1, 32'h0, 1, 6'd0, 32'h0, 32'h100, 32'h20);
    step(1); idle();
    chk("cbz_occ_before_issue", occupancy, 1);
    step(1);
    chk("cbz_issue_valid", bus.issue_valid, 1);
    chk("cbz_issue_pc", bus.issue_pc, 32'h100);
    chk("cbz_issue_imm", bus.issue_imm, 32'h20);
    chk("cbz_issue_rob", bus.issue_rob_tag, 5);
    chk("cbz_occ_after", occupancy, 0);
    step(1);

    // CBNZ waiting on tag 12
    set_disp(8'hB8, 6'd6, 0, 6'd12, 32'h0, 1, 6'd0, 32'h0, 32'h200, 32'h40);
    step(1); idle(); step(2);
    set_cdb(6'd12, 32'd7);
    step(1); idle();
    chk("cbnz_wait_no_issue", bus.issue_valid, 0);
    step(1);
    chk("cbnz_issue_valid", bus.issue_valid, 1);
    chk("cbnz_src1_val", bus.issue_src1_val, 7);
    step(1);

    // Younger ready entry passes older blocked one
    set_disp(8'h10, 6'd10, 0, 6'd3, 32'h0, 1, 6'd0, 32'h0, 32'h300, 32'h4);
    step(1);
    set_disp(8'h11, 6'd11, 1, 6'd0, 32'h1, 1, 6'd0, 32'h2, 32'h304, 32'h8);
    step(1); idle(); step(1);
    chk("order_b_first", bus.issue_rob_tag, 11);
    set_cdb(6'd3, 32'h33);
    step(1); idle(); step(1);
    chk("order_a_rob", bus.issue_rob_tag, 10);
    chk("order_a_src1", bus.issue_src1_val, 32'h33);
    step(1);

    // Fill, overflow attempt, wake the oldest
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(8'h20, 6'(20 + i), 0, 6'(20 + i), 32'h0, 1, 6'd0, 32'h0, 32'(32'h400 + 4 * i), 32'h0);
      step(1);
    end
    chk("full_occ", occupancy, 4);
    chk("full_not_ready", bus.disp_ready, 0);
    set_disp(8'h21, 6'd24, 1, 6'd0, 32'h0, 1, 6'd0, 32'h0, 32'h500, 32'h0);
    step(1); idle();
    chk("full_drop_occ", occupancy, 4);
    set_cdb(6'd20, 32'hA0);
    step(1); idle(); step(1);
    chk("full_wake_rob", bus.issue_rob_tag, 20);
    chk("full_wake_occ", occupancy, 3);
    chk("full_wake_ready", bus.disp_ready, 1);
    set_cdb(6'd21, 32'hA1); step(1);
    set_cdb(6'd22, 32'hA2); step(1);
    set_cdb(6'd23, 32'hA3); step(1);
    idle(); step(3);

    // Dispatch coinciding with matching CDB
    set_disp(8'h30, 6'd30, 0, 6'd30, 32'h0, 1, 6'd0, 32'h9, 32'h600, 32'hC);
    set_cdb(6'd30, 32'h55);
    step(1); idle(); step(1);
    chk("cdb_disp_issue", bus.issue_valid, 1);
    chk("cdb_disp_src1", bus.issue_src1_val, 32'h55);
    step(1);

    // Flush with a concurrent dispatch
    for (int i = 0; i < 3; i++) begin
      set_disp(8'h40, 6'(40 + i), 0, 6'(40 + i), 32'h0, 1, 6'd0, 32'h0, 32'h700, 32'h0);
      step(1);
    end
    set_disp(8'h41, 6'd50, 1, 6'd0, 32'h0, 1, 6'd0, 32'h0, 32'h800, 32'h0);
    bus.flush = 1;
    step(1); idle();
    chk("flush_occ", occupancy, 0);
    chk("flush_issue_valid", bus.issue_valid, 0);
    set_cdb(6'd40, 32'h1);
    step(1); idle(); step(2);
    chk("flush_nothing_issues", bus.issue_valid, 0);

    // Random traffic with one asynchronous reset in the middle
    for (int c = 0; c < 1500; c++) begin
      idle();
      if ($urandom_range(0, 99) < 60)
        set_disp(8'($urandom), 6'($urandom_range(0, 63)),
                 1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), $urandom,
                 $urandom, $urandom);
      if ($urandom_range(0, 99) < 50) set_cdb(6'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 99) < 3) bus.flush = 1;
      if (c == 700) begin
        idle();
        #2 reset = 1;
        #1;
        chk("async_rst_issue_valid", bus.issue_valid, 0);
        chk("async_rst_occ", occupancy, 0);
        chk("async_rst_issue_pc", bus.issue_pc, 0);
        chk("async_rst_ready", bus.disp_ready, 1);
        @(negedge clk);
        reset = 0;
      end
      step(1);
    end
    idle();
    step(10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
